// File: rtl/cpu_fetch_pkg.sv
// -----------------------------------------------------------------------------
// cpu_fetch_pkg
//   Shared types and constants for the fetch stage of the 16-bit pipelined CPU.
//   - fetch_state_t : fetch controller states (PRIME after reset, RUN after)
//   - NOP           : the all-zero instruction word used for bubbles
//   - fd_payload_t  : contents of the fetch/decode pipeline register
//   - fd_bubble()   : helper returning a bubble payload
// -----------------------------------------------------------------------------
package cpu_fetch_pkg;

    // Widths of the fetch/decode payload. The cpu_fetch parameters default
    // to these values, and the payload struct is sized by them.
    localparam int FD_WIDTH            = 16;
    localparam int FD_INSTRUCTIONWIDTH = 24;

    // PRIME: memory has no valid data yet. RUN: imemData belongs to fetchPC.
    typedef enum logic [0:0] {
        PRIME = 1'b0,
        RUN   = 1'b1
    } fetch_state_t;

    localparam logic [FD_INSTRUCTIONWIDTH-1:0] NOP = '0;

    typedef struct packed {
        logic [FD_INSTRUCTIONWIDTH-1:0] instruction;
        logic [FD_WIDTH-1:0]            pc;
        logic                           valid;
    } fd_payload_t;

    // A bubble is a NOP at PC 0 marked not-valid, so decode ignores it.
    function automatic fd_payload_t fd_bubble();
        fd_payload_t bubble_s;
        bubble_s.instruction = NOP;
        bubble_s.pc          = {FD_WIDTH{1'b0}};
        bubble_s.valid       = 1'b0;
        return bubble_s;
    endfunction

endpackage

// File: rtl/fetch_decode_register.sv
// -----------------------------------------------------------------------------
// fetch_decode_register
//   Fetch/decode pipeline register holding one instruction/PC/valid payload.
//   Priority: reset > flush (bubble load) > enable (load) > hold.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset, loads a bubble
//   enable      in   load payload_in when high (driven as !stallD)
//   flush       in   load a bubble, overriding enable
//   payload_in  in   instruction/pc/valid from fetch
//   payload_out out  registered payload presented to decode
// -----------------------------------------------------------------------------
module fetch_decode_register
    import cpu_fetch_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        flush,
    input  fd_payload_t payload_in,
    output fd_payload_t payload_out
);

    fd_payload_t payload_r;

    // Payload register: bubble on reset or flush, load when enabled, else hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            payload_r <= fd_bubble();
        end else if (flush) begin
            payload_r <= fd_bubble();
        end else if (enable) begin
            payload_r <= payload_in;
        end else begin
            payload_r <= payload_r;
        end
    end

    assign payload_out = payload_r;

endmodule

// File: rtl/cpu_fetch.sv
// -----------------------------------------------------------------------------
// cpu_fetch
//   Fetch stage: owns the program counter, drives a synchronous (1-cycle
//   latency) instruction memory and fills the fetch/decode register.
// Parameters:
//   WIDTH            PC / address width
//   INSTRUCTIONWIDTH instruction word width
//   RESETPC          first instruction address after reset
// Ports:
//   clock        in   single rising-edge clock
//   reset        in   synchronous active-high reset
//   stallF       in   hold PC and re-read the current address
//   stallD       in   hold the fetch/decode register (only legal with stallF)
//   flushD       in   load a bubble into the fetch/decode register
//   redirectE    in   taken branch/jump resolved in execute
//   targetE      in   redirect target address
//   imemAddress  out  instruction memory address (combinational)
//   imemData     in   memory data for the address presented last cycle
//   InstructionD out  instruction to decode
//   PCD          out  address of InstructionD
//   validD       out  InstructionD is a real instruction, not a bubble
// -----------------------------------------------------------------------------
module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter int               WIDTH            = FD_WIDTH,
    parameter int               INSTRUCTIONWIDTH = FD_INSTRUCTIONWIDTH,
    parameter logic [WIDTH-1:0] RESETPC          = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        stallF,
    input  logic                        stallD,
    input  logic                        flushD,
    input  logic                        redirectE,
    input  logic [WIDTH-1:0]            targetE,
    output logic [WIDTH-1:0]            imemAddress,
    input  logic [INSTRUCTIONWIDTH-1:0] imemData,
    output logic [INSTRUCTIONWIDTH-1:0] InstructionD,
    output logic [WIDTH-1:0]            PCD,
    output logic                        validD
);

    // fetch_pc_r is the address whose data is on imemData this cycle.
    fetch_state_t           state_r;
    fetch_state_t           state_next_s;
    logic [WIDTH-1:0]       fetch_pc_r;
    logic [WIDTH-1:0]       pc_seq_s;
    logic [WIDTH-1:0]       next_addr_s;
    logic                   fd_flush_s;
    logic                   fd_enable_s;
    fd_payload_t            fd_in_s;
    fd_payload_t            fd_out_s;

    // Sequential address; the natural WIDTH-bit wrap takes 16'hFFFF to 0.
    assign pc_seq_s = fetch_pc_r + {{(WIDTH-1){1'b0}}, 1'b1};

    // Next-state, next-address mux and fetch/decode register control.
    always_comb begin
        state_next_s = state_r;
        next_addr_s  = RESETPC;
        fd_flush_s   = 1'b1;
        fd_enable_s  = ~stallD;
        if (reset) begin
            // Reset: present RESETPC so the restart sequence is identical.
            state_next_s = PRIME;
            next_addr_s  = RESETPC;
            fd_flush_s   = 1'b1;
        end else begin
            case (state_r)
                PRIME: begin
                    // imemData is not valid yet: start at RESETPC, bubble D.
                    state_next_s = RUN;
                    next_addr_s  = RESETPC;
                    fd_flush_s   = 1'b1;
                end
                RUN: begin
                    state_next_s = RUN;
                    if (redirectE) begin
                        next_addr_s = targetE;
                    end else if (stallF) begin
                        next_addr_s = fetch_pc_r;
                    end else begin
                        next_addr_s = pc_seq_s;
                    end
                    // Redirect squashes the wrong-path word on imemData.
                    // A fetch-only stall bubbles D; stallD holds D instead.
                    fd_flush_s = redirectE | flushD | (stallF & ~stallD);
                end
                default: begin
                    state_next_s = PRIME;
                    next_addr_s  = RESETPC;
                    fd_flush_s   = 1'b1;
                end
            endcase
        end
    end

    // Payload offered to the fetch/decode register: current memory word.
    always_comb begin
        fd_in_s             = fd_bubble();
        fd_in_s.instruction = imemData;
        fd_in_s.pc          = fetch_pc_r;
        fd_in_s.valid       = 1'b1;
    end

    // State register and fetchPC; fetchPC follows imemAddress every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= PRIME;
            fetch_pc_r <= RESETPC;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= next_addr_s;
        end
    end

    assign imemAddress = next_addr_s;

    fetch_decode_register u_fd_reg (
        .clock       (clock),
        .reset       (reset),
        .enable      (fd_enable_s),
        .flush       (fd_flush_s),
        .payload_in  (fd_in_s),
        .payload_out (fd_out_s)
    );

    assign InstructionD = fd_out_s.instruction;
    assign PCD          = fd_out_s.pc;
    assign validD       = fd_out_s.valid;

endmodule

// File: tb/tb_cpu_fetch.sv
// -----------------------------------------------------------------------------
// tb_cpu_fetch
//   Self-checking bench for cpu_fetch: directed scenarios followed by
//   randomized stall/flush/redirect/reset traffic, all compared against a
//   cycle-level transaction model of the fetch stage.
// -----------------------------------------------------------------------------
module tb_cpu_fetch;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        redirectE;
    logic [15:0] targetE;
    logic [15:0] imemAddress;
    logic [23:0] imemData;
    logic [23:0] InstructionD;
    logic [15:0] PCD;
    logic        validD;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model state: which word is arriving from memory, and the
    // expected decode-side triple.
    logic        m_known = 1'b0;
    logic        m_pend_ok;
    logic [15:0] m_pend_pc;
    logic [23:0] m_instr;
    logic [15:0] m_pc;
    logic        m_valid;

    cpu_fetch #(
        .WIDTH            (16),
        .INSTRUCTIONWIDTH (24),
        .RESETPC          (RST_PC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .stallF       (stallF),
        .stallD       (stallD),
        .flushD       (flushD),
        .redirectE    (redirectE),
        .targetE      (targetE),
        .imemAddress  (imemAddress),
        .imemData     (imemData),
        .InstructionD (InstructionD),
        .PCD          (PCD),
        .validD       (validD)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] mem_word(input logic [15:0] a);
        return 24'h100000 + {8'h00, a};
    endfunction

    // Synchronous instruction memory, one cycle of read latency.
    always @(posedge clock) imemData <= mem_word(imemAddress);

    // The hazard unit never raises stallD without stallF.
    always @(posedge clock) begin
        assert (!(stallD && !stallF)) else $error("illegal stallD without stallF");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Address the fetch stage should be presenting this cycle.
    function automatic logic [15:0] model_addr();
        if (reset || !m_pend_ok) return RST_PC;
        else if (redirectE)      return targetE;
        else if (stallF)         return m_pend_pc;
        else                     return m_pend_pc + 16'd1;
    endfunction

    // Advance the model across one rising edge.
    task automatic model_step();
        logic [15:0] nxt;
        if (reset) begin
            m_instr   = 24'h0;
            m_pc      = 16'h0;
            m_valid   = 1'b0;
            m_pend_ok = 1'b0;
            m_pend_pc = RST_PC;
            m_known   = 1'b1;
        end else begin
            nxt = model_addr();
            if (!m_pend_ok || redirectE || flushD || (stallF && !stallD)) begin
                m_instr = 24'h0;
                m_pc    = 16'h0;
                m_valid = 1'b0;
            end else if (!stallD) begin
                m_instr = mem_word(m_pend_pc);
                m_pc    = m_pend_pc;
                m_valid = 1'b1;
            end else begin
                m_valid = m_valid;
            end
            m_pend_pc = nxt;
            m_pend_ok = 1'b1;
        end
    endtask

    // One clock cycle: check last edge's D outputs, apply inputs, check the
    // combinational address, then step the model on the rising edge.
    task automatic cyc(input logic r, input logic sf, input logic sd,
                       input logic fl, input logic rd, input logic [15:0] tg);
        @(negedge clock);
        if (m_known) begin
            check_val("validD", 32'(validD), 32'(m_valid));
            check_val("PCD", 32'(PCD), 32'(m_pc));
            check_val("InstructionD", 32'(InstructionD), 32'(m_instr));
        end
        reset     = r;
        stallF    = sf;
        stallD    = sd;
        flushD    = fl;
        redirectE = rd;
        targetE   = tg;
        #1;
        check_val("imemAddress", 32'(imemAddress), 32'(model_addr()));
        @(posedge clock);
        model_step();
    endtask

    // Directed expectation with hand-written constants, just after an edge.
    task automatic expect_d(input string tag, input logic [15:0] pc, input logic v);
        #2;
        check_val({tag, ".valid"}, 32'(validD), 32'(v));
        check_val({tag, ".pc"}, 32'(PCD), 32'(v ? pc : 16'h0));
        check_val({tag, ".instr"}, 32'(InstructionD), 32'(v ? mem_word(pc) : 24'h0));
    endtask

    task automatic idle(); cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0); endtask

    initial begin
        logic r, sf, sd, fl, rd;
        logic [15:0] tg;
        reset = 1'b1; stallF = 1'b0; stallD = 1'b0;
        flushD = 1'b0; redirectE = 1'b0; targetE = 16'h0;

        // Reset, then in-order stream from RESETPC.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        expect_d("reset", 16'h0, 1'b0);
        idle(); expect_d("prime", 16'h0, 1'b0);
        idle(); expect_d("first", 16'h0, 1'b1);
        idle(); expect_d("seq1", 16'h1, 1'b1);
        idle(); expect_d("seq2", 16'h2, 1'b1);
        idle(); expect_d("seq3", 16'h3, 1'b1);
        idle(); idle(); expect_d("seq5", 16'h5, 1'b1);

        // Full stall for 3 cycles holds PCD = 5, then 6, 7 follow.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
            expect_d("hold5", 16'h5, 1'b1);
        end
        idle(); expect_d("after_stall6", 16'h6, 1'b1);
        idle(); expect_d("after_stall7", 16'h7, 1'b1);

        // Fetch-only stall: one bubble, then the next instruction.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        expect_d("stallF_bubble", 16'h0, 1'b0);
        idle(); expect_d("stallF_next", 16'h8, 1'b1);

        // Redirect while fetchPC = 9: bubble, then target.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0040);
        expect_d("redir_bubble", 16'h0, 1'b0);
        idle(); expect_d("redir_target", 16'h0040, 1'b1);

        // Redirect with stallF and flushD, near the top of memory, then wrap.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFE);
        expect_d("redir_stall_bubble", 16'h0, 1'b0);
        idle(); expect_d("wrap_fffe", 16'hFFFE, 1'b1);
        idle(); expect_d("wrap_ffff", 16'hFFFF, 1'b1);
        idle(); expect_d("wrap_0", 16'h0000, 1'b1);

        // One-cycle reset mid-stream, then the restart sequence again.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        expect_d("mid_reset", 16'h0, 1'b0);
        idle(); expect_d("re_prime", 16'h0, 1'b0);
        idle(); expect_d("re_first", 16'h0, 1'b1);
        idle(); expect_d("re_seq1", 16'h1, 1'b1);
        idle(); expect_d("re_seq2", 16'h2, 1'b1);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            r  = ($urandom_range(99) == 0);
            sf = ($urandom_range(99) < 20);
            sd = sf && ($urandom_range(1) == 1);
            fl = ($urandom_range(99) < 8);
            rd = ($urandom_range(99) < 8);
            tg = ($urandom_range(3) == 0) ? 16'(16'hFFF0 + 16'($urandom_range(15)))
                                          : 16'($urandom_range(16'hFFFF));
            cyc(r, sf, sd, fl, rd, tg);
        end
        idle();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/cpu_fetch.md
# cpu_fetch

Fetch stage of the 16-bit pipelined CPU and the producer side of the fetch/decode boundary. It owns the program counter, drives a synchronous (1-cycle read latency) instruction memory, and delivers instruction/PC pairs into the decode stage through its fetch/decode pipeline register. It honours stall and flush requests from the hazard unit and branch redirects from execute, and inserts bubbles where required.

## Interface
- WIDTH, 16, PC and address width
- INSTRUCTIONWIDTH, 24, instruction word width
- RESETPC, 0, first instruction address after reset
- clock  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- stallF  input  1  hold PC; re-read the current address
- stallD  input  1  hold the fetch/decode register contents
- flushD  input  1  load a bubble into the fetch/decode register
- redirectE  input  1  taken branch/jump resolved in execute
- targetE  input  WIDTH  redirect target address
- imemAddress  output  WIDTH  instruction memory address, combinational
- imemData  input  INSTRUCTIONWIDTH  memory data for the address presented last cycle
- InstructionD  output  INSTRUCTIONWIDTH  instruction to decode
- PCD  output  WIDTH  address of InstructionD
- validD  output  1  InstructionD is a real instruction, not a bubble

## Operation
- PC is word-addressed: sequential next address = fetchPC + 1, modulo 2^WIDTH; 16'hFFFF wraps to 0.
- fetchPC register holds the address whose data is on imemData this cycle. It is updated to imemAddress every non-reset cycle.
- State machine, 2 states:
  - PRIME is the reset state. imemAddress = RESETPC. imemData is not valid. The fetch/decode register loads a bubble. Next state is always RUN.
  - RUN: imemData is valid for fetchPC. State stays RUN until reset.
- imemAddress in RUN, in priority order:
  - redirectE: targetE
  - stallF: fetchPC
  - otherwise: fetchPC+1
- Fetch/decode register update in RUN, in priority order:
  - redirectE or flushD: bubble. InstructionD = NOP (all zeros), PCD = 0, validD = 0.
  - stallD: hold all three outputs.
  - stallF: bubble.
  - otherwise: InstructionD = imemData, PCD = fetchPC, validD = 1.
- redirectE squashes the wrong-path word currently on imemData. Decode/execute squashing is owned by the hazard unit, not this block.
- stallD without stallF is illegal. The bench asserts it never occurs; RTL behaviour in that case is don't-care.
- redirectE together with stallF: redirect wins, and the PC moves to targetE.

## Timing
- Reset values: InstructionD = 0, PCD = 0, validD = 0, fetchPC = RESETPC, state = PRIME. While reset is high, imemAddress = RESETPC.
- Reset is synchronous; asserting it mid-operation discards all in-flight fetches at the next edge.
- After reset deasserts:
  - cycle 0 (PRIME): address RESETPC is presented.
  - cycle 1: imemData = mem[RESETPC].
  - end of cycle 1: InstructionD = mem[RESETPC], validD = 1.
- Steady state: one instruction per cycle. An address presented in cycle N appears on InstructionD after the edge ending cycle N+1.
- Redirect in cycle N:
  - targetE is presented in cycle N.
  - D receives a bubble at end of N.
  - mem[targetE] reaches D at end of N+1.
  - Redirect penalty is one bubble from this block.
- Stall: outputs and fetchPC are held exactly for the stalled cycles. No instruction is lost or duplicated when the stall releases.

## Structure
- Package cpu_fetch_pkg holds:
  - the state enum {PRIME, RUN}
  - localparam NOP = '0
  - a packed struct for the fetch/decode payload {instruction, pc, valid}
- Sub-module fetch_decode_register implements the payload register with sync reset, enable (= !stallD) and bubble load (flush) inputs.
- Next-address mux, fetchPC and the state machine live in cpu_fetch.

## Test plan
- Reset release, mem[i] = 24'h100000+i, no stalls -> validD first high at end of cycle 1; PCD goes 0,1,2,3 on consecutive cycles with matching InstructionD.
- stallF = stallD = 1 for 3 cycles while PCD = 5 -> PCD = 5 and its InstructionD held 3 cycles; then 6, 7 follow with no gap or repeat.
- stallF = 1, stallD = 0 for 1 cycle at PCD = 2 -> one cycle validD = 0; then PCD = 3.
- redirectE = 1, targetE = 16'h0040 while fetchPC = 9 -> next D entry is a bubble; following entry has PCD = 40, InstructionD = mem[40].
- redirectE together with stallF and flushD -> redirect taken, bubble in D, PC = targetE. Separately, fetchPC = 16'hFFFF -> next PCD = 0.
- reset pulsed for one cycle mid-stream -> at the following edge validD = 0, PCD = 0; restart sequence identical to the first scenario.
